// File: rtl/de1_pio_pkg.sv
// Shared register map and edge-selection constants for the DE1 input PIO.
package de1_pio_pkg;

    localparam int BUS_WIDTH = 32;

    typedef logic [1:0]           addr_t;
    typedef logic [BUS_WIDTH-1:0] word_t;

    localparam addr_t ADDR_DATA    = 2'd0;
    localparam addr_t ADDR_RSVD    = 2'd1;
    localparam addr_t ADDR_IRQMASK = 2'd2;
    localparam addr_t ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/de1_key_input_pio_if.sv
// Avalon-MM slave window of the input PIO, including its level interrupt.
interface de1_key_input_pio_if;
    import de1_pio_pkg::*;

    addr_t address;
    logic  chipselect;
    logic  write_n;
    word_t writedata;
    word_t readdata;
    logic  irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/de1_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time debounce counter.
module de1_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= IDLE_LEVEL;
            sync_q2 <= IDLE_LEVEL;
            stable  <= IDLE_LEVEL;
            cnt     <= '0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            // A bounce back to the accepted level restarts the hold count.
            if (sync_q2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de1_key_input_pio.sv
// Debounced input PIO with sticky edge capture, write-1-to-clear, and a maskable level IRQ.
module de1_key_input_pio
    import de1_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   in_port,
    de1_key_input_pio_if.slave bus
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel_edges;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic             irq_q;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        de1_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_LEVEL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[gi]),
            .stable  (stable[gi])
        );
    end

    assign rise = stable & ~prev;
    assign fall = ~stable & prev;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_edges = fall;
        if (EDGE_TYPE == EDGE_RISE) sel_edges = rise;
        else if (EDGE_TYPE == EDGE_ANY) sel_edges = rise | fall;
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign clr_bits     = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^bus.writedata;

    // NOTE: all control registers are reset explicitly; there is no memory here left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= {WIDTH{IDLE_LEVEL}};
            irq_mask     <= '0;
            edge_capture <= '0;
            irq_q        <= 1'b0;
        end else begin
            prev <= stable;
            if (wr_en && bus.address == ADDR_IRQMASK) irq_mask <= bus.writedata[WIDTH-1:0];
            // Set has priority over a simultaneous write-1-to-clear.
            edge_capture <= (edge_capture & ~clr_bits) | sel_edges;
            irq_q        <= |(edge_capture & irq_mask);
        end
    end

    assign bus.irq = irq_q;

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            ADDR_DATA:    bus.readdata = BUS_WIDTH'(stable);
            ADDR_RSVD:    bus.readdata = '0;
            ADDR_IRQMASK: bus.readdata = BUS_WIDTH'(irq_mask);
            ADDR_EDGECAP: bus.readdata = BUS_WIDTH'(edge_capture);
            default:      bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_de1_key_input_pio.sv
// Directed bench for de1_key_input_pio: a falling-edge instance and an any-edge instance share the pins and bus traffic.
module tb_de1_key_input_pio;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'hF;

    int n_checks = 0;
    int n_pass   = 0;

    de1_key_input_pio_if bus_f ();
    de1_key_input_pio_if bus_a ();

    de1_key_input_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_f)
    );

    de1_key_input_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) u_dut_any (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus_a)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    typedef struct {
        logic        cs;
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        bus_f.chipselect = cs; bus_f.write_n = wn; bus_f.address = a; bus_f.writedata = d;
        bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = d;
    endtask

    task automatic wr_raw(input logic cs, input logic we, input logic [1:0] a, input logic [31:0] d);
        set_bus(cs, ~we, a, d);
        tick();
        set_bus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_raw(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] df, output logic [31:0] da);
        set_bus(1'b1, 1'b1, a, 32'h0);
        #1;
        df = bus_f.readdata;
        da = bus_a.readdata;
        set_bus(1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic wait_for(input logic [1:0] a, input logic [31:0] msk, input logic [31:0] exp,
                            input int limit, output int cycles);
        logic [31:0] df, da;
        cycles = 0;
        do begin
            tick();
            cycles++;
            rd(a, df, da);
        end while (((df & msk) != exp) && cycles < limit);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] df, da;
        int          cyc;
        int          early;

        vecs[0] = '{1'b1, 1'b1, 2'd2, 32'h0000_0005, 2'd2, 32'h5, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'd2, 32'h0000_000A, 2'd2, 32'h5, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'hF, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'hF, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h0000_FFFF, 2'd1, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'd3, 32'h0000_000F, 2'd3, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 2'd2, 32'hF, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 2'd2, 32'h0, 1'b0};

        set_bus(1'b0, 1'b1, 2'd0, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Reset state
        rd(2'd0, df, da); check("reset_data", df, 32'hF);
        rd(2'd2, df, da); check("reset_mask", df, 32'h0);
        rd(2'd3, df, da); check("reset_edgecap", df, 32'h0);
        check("reset_irq", {31'h0, bus_f.irq}, 32'h0);

        // Register access vectors
        for (int i = 0; i < 8; i++) begin
            wr_raw(vecs[i].cs, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, df, da);
            check($sformatf("vec%0d_rd", i), df, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'h0, bus_f.irq}, {31'h0, vecs[i].exp_irq});
        end

        // Clean falling edge on bit 0
        in_port = 4'hE;
        wait_for(2'd0, 32'hF, 32'hE, 40, cyc);
        check("fall0_latency", cyc, 10);
        tick();
        rd(2'd3, df, da);
        check("fall0_cap", df, 32'h1);
        check("fall0_cap_any", da, 32'h1);
        tick();
        check("fall0_irq_masked", {31'h0, bus_f.irq}, 32'h0);

        // Bounce on bit 1: low 5, high 1, then held low
        early = 0;
        in_port = 4'hC;
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(2'd3, df, da);
            if (df[1]) early++;
        end
        in_port = 4'hE;
        tick();
        rd(2'd3, df, da);
        if (df[1]) early++;
        in_port = 4'hC;
        wait_for(2'd3, 32'h2, 32'h2, 40, cyc);
        check("bounce_no_early", early, 0);
        check("bounce_cap_latency", cyc, 11);
        rd(2'd3, df, da);
        check("bounce_cap", df, 32'h3);
        wr(2'd3, 32'h2);
        rd(2'd3, df, da);
        check("w1c_bit1", df, 32'h1);

        // Mask enables irq, W1C clears it
        wr(2'd2, 32'h3);
        check("irq_lag0", {31'h0, bus_f.irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, bus_f.irq}, 32'h1);
        rd(2'd2, df, da);
        check("mask_rd", df, 32'h3);
        wr(2'd3, 32'h1);
        rd(2'd3, df, da);
        check("w1c_bit0", df, 32'h0);
        check("irq_hold", {31'h0, bus_f.irq}, 32'h1);
        tick();
        check("irq_clear", {31'h0, bus_f.irq}, 32'h0);

        // Rising edge on bit 0: ignored by falling instance, captured by any-edge instance
        in_port = 4'hD;
        wait_for(2'd0, 32'hF, 32'hD, 40, cyc);
        check("rise0_latency", cyc, 10);
        tick();
        tick();
        rd(2'd3, df, da);
        check("rise0_cap_fall", df, 32'h0);
        check("rise0_cap_any", da, 32'h1);
        check("rise0_irq_fall", {31'h0, bus_f.irq}, 32'h0);
        check("rise0_irq_any", {31'h0, bus_a.irq}, 32'h1);
        wr(2'd3, 32'hF);

        // Edge captured in the same cycle as a W1C of that bit: set wins
        in_port = 4'h9;
        repeat (10) tick();
        rd(2'd3, df, da);
        check("collide_pre", df, 32'h0);
        wr(2'd3, 32'hF);
        rd(2'd3, df, da);
        check("collide_fall", df, 32'h4);
        check("collide_any", da, 32'h4);
        tick();
        check("collide_irq", {31'h0, bus_f.irq}, 32'h0);

        // Reset mid-debounce with a capture pending
        wr(2'd2, 32'hF);
        tick();
        check("pre_reset_irq", {31'h0, bus_f.irq}, 32'h1);
        in_port = 4'h1;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        rd(2'd0, df, da); check("rst_data", df, 32'hF);
        rd(2'd2, df, da); check("rst_mask", df, 32'h0);
        rd(2'd3, df, da); check("rst_edgecap", df, 32'h0);
        check("rst_irq", {31'h0, bus_f.irq}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_for(2'd0, 32'hF, 32'h1, 40, cyc);
        check("post_reset_latency", cyc, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
